// File: rtl/lsu_bus_bridge_if.sv
// Ready-handshaked data bus between the LSU bridge and memory/peripherals.
// The bridge drives the request side; the memory answers with rd/ready.
interface lsu_bus_bridge_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;

  modport master (
    output req, we, be, addr, wd,
    input  rd, ready
  );

  modport slave (
    input  req, we, be, addr, wd,
    output rd, ready
  );
endinterface

// File: rtl/lsu_bus_bridge.sv
// Core data-port responder: size/lane conversion, stall generation,
// load extension and a watchdog on the ready-handshaked memory bus.
module lsu_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             core_req_i,
  input  logic             core_we_i,
  input  logic [2:0]       core_size_i,
  input  logic [31:0]      core_addr_i,
  input  logic [31:0]      core_wd_i,
  output logic [31:0]      core_rd_o,
  output logic             core_stall_o,
  output logic             core_err_o,
  lsu_bus_bridge_if.master mem
);

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  logic             done_q,  done_d;
  logic             err_q,   err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [2:0]       size_q,  size_d;
  logic [1:0]       off_q,   off_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic illegal;
  logic active;
  logic bus_req;

  always_comb begin
    illegal = 1'b0;
    case (core_size_i)
      SZ_B:    illegal = 1'b0;
      SZ_BU:   illegal = core_we_i;
      SZ_H:    illegal = core_addr_i[0];
      SZ_HU:   illegal = core_we_i | core_addr_i[0];
      SZ_W:    illegal = |core_addr_i[1:0];
      default: illegal = 1'b1;
    endcase
  end

  // Reset gates the request so nothing leaks onto the bus while held.
  assign active  = rst_i & core_req_i & ~done_q & ~err_q;
  assign bus_req = active & ~illegal;

  assign mem.req      = bus_req;
  assign mem.we       = core_we_i;
  assign mem.addr     = {core_addr_i[31:2], 2'b00};
  assign core_stall_o = bus_req;
  assign core_err_o   = err_q;

  always_comb begin
    mem.be = 4'b0000;
    mem.wd = core_wd_i;
    case (core_size_i[1:0])
      2'd0: begin
        mem.be = 4'b0001 << core_addr_i[1:0];
        mem.wd = {4{core_wd_i[7:0]}};
      end
      2'd1: begin
        mem.be = core_addr_i[1] ? 4'b1100 : 4'b0011;
        mem.wd = {2{core_wd_i[15:0]}};
      end
      2'd2: mem.be = 4'b1111;
      default: mem.be = 4'b0000;
    endcase
    if (!bus_req) mem.be = 4'b0000;
  end

  always_comb begin
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    size_d  = size_q;
    off_d   = off_q;
    cnt_d   = '0;
    if (active && illegal) begin
      err_d = 1'b1;
    end else if (bus_req && mem.ready) begin
      done_d  = 1'b1;
      rdata_d = mem.rd;
      size_d  = core_size_i;
      off_d   = core_addr_i[1:0];
    end else if (bus_req) begin
      if (cnt_q == CNT_LAST) err_d = 1'b1;
      else cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      size_q  <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end

  logic [31:0] lane;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign lane  = rdata_q >> {off_q, 3'b000};
  assign rbyte = lane[7:0];
  assign rhalf = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];

  always_comb begin
    core_rd_o = rdata_q;
    case (size_q)
      SZ_B:    core_rd_o = {{24{rbyte[7]}}, rbyte};
      SZ_BU:   core_rd_o = {24'b0, rbyte};
      SZ_H:    core_rd_o = {{16{rhalf[15]}}, rhalf};
      SZ_HU:   core_rd_o = {16'b0, rhalf};
      default: core_rd_o = rdata_q;
    endcase
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Scoreboarded bench for lsu_bus_bridge: loads, stores, waits,
// illegal accesses, watchdog timeout and reset during an access.
module tb_lsu_bus_bridge;

  logic        clk;
  logic        rst_i;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        core_err_o;

  lsu_bus_bridge_if bus ();

  lsu_bus_bridge #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(5)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .core_req_i  (core_req_i),
    .core_we_i   (core_we_i),
    .core_size_i (core_size_i),
    .core_addr_i (core_addr_i),
    .core_wd_i   (core_wd_i),
    .core_rd_o   (core_rd_o),
    .core_stall_o(core_stall_o),
    .core_err_o  (core_err_o),
    .mem         (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    int          stall;
    bit          chk_rd;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  // Drives one access and records what the DUT did; checks live in tests.
  task automatic drive_access(
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [31:0] mrd,
    input  int          waits,
    output int          stall_cyc,
    output int          req_cyc,
    output logic [31:0] rd,
    output logic [3:0]  be,
    output logic [31:0] wdo,
    output logic [31:0] ao,
    output logic        weo,
    output bit          err_seen
  );
    int  k;
    bit  done;
    stall_cyc = 0; req_cyc = 0; rd = '0; be = '0;
    wdo = '0; ao = '0; weo = 1'b0; err_seen = 0;
    k = 0; done = 0;
    @(posedge clk); #1;
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = size;
    core_addr_i = addr;
    core_wd_i   = wd;
    bus.rd      = mrd;
    bus.ready   = (waits == 0);
    while (!done && k < 40) begin
      @(negedge clk);
      if (core_err_o) err_seen = 1;
      if (bus.req) req_cyc++;
      if (core_stall_o) begin
        stall_cyc++;
        be  = bus.be;
        wdo = bus.wd;
        ao  = bus.addr;
        weo = bus.we;
      end else begin
        rd   = core_rd_o;
        done = 1;
      end
      @(posedge clk); #1;
      k++;
      bus.ready = (k >= waits);
    end
    core_req_i = 1'b0;
    bus.ready  = 1'b0;
    if (!done) stall_cyc = -1;
  endtask

  task automatic test_reset;
    rst_i = 1'b0;
    core_req_i = 1'b1;
    core_we_i = 1'b0;
    core_size_i = 3'd2;
    core_addr_i = 32'h100;
    core_wd_i = '0;
    bus.rd = 32'hFFFF_FFFF;
    bus.ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req got=%b want=0", bus.req);
    end
    vectors++;
    if (core_stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall got=%b want=0", core_stall_o);
    end
    vectors++;
    if (core_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_err got=%b want=0", core_err_o);
    end
    vectors++;
    if (core_rd_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rd got=%h want=0", core_rd_o);
    end
    core_req_i = 1'b0;
    bus.ready = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lw;
    int sc, rc; logic [31:0] rd, wdo, ao; logic [3:0] be;
    logic weo; bit es; exp_t e;
    sb.push_back('{32'hDEADBEEF, 1, 1'b1});
    drive_access(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0,
                 sc, rc, rd, be, wdo, ao, weo, es);
    e = sb.pop_front();
    vectors++;
    if (rd !== e.rd) begin
      miscompares++;
      $display("FAIL lw_rd got=%h want=%h", rd, e.rd);
    end
    vectors++;
    if (sc !== e.stall) begin
      miscompares++;
      $display("FAIL lw_stall got=%0d want=%0d", sc, e.stall);
    end
    vectors++;
    if (be !== 4'b1111 || ao !== 32'h100 || weo !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_bus be=%b addr=%h we=%b want 1111/100/0",
               be, ao, weo);
    end
    vectors++;
    if (es !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_err got=%b want=0", es);
    end
  endtask

  typedef struct {
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] mrd;
    logic [31:0] rd;
    logic [3:0]  be;
  } ld_t;

  task automatic test_loads;
    ld_t t[7];
    int sc, rc; logic [31:0] rd, wdo, ao; logic [3:0] be;
    logic weo; bit es; exp_t e;
    t[0] = '{3'd0, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80, 4'b1000};
    t[1] = '{3'd4, 32'h103, 32'h80FF_0000, 32'h0000_0080, 4'b1000};
    t[2] = '{3'd1, 32'h102, 32'h80FF_0000, 32'hFFFF_80FF, 4'b1100};
    t[3] = '{3'd5, 32'h100, 32'h1234_8001, 32'h0000_8001, 4'b0011};
    t[4] = '{3'd1, 32'h100, 32'h1234_8001, 32'hFFFF_8001, 4'b0011};
    t[5] = '{3'd4, 32'h101, 32'h1234_8001, 32'h0000_0080, 4'b0010};
    t[6] = '{3'd0, 32'h102, 32'h1274_8001, 32'h0000_0074, 4'b0100};
    foreach (t[i]) begin
      sb.push_back('{t[i].rd, 1, 1'b1});
      drive_access(1'b0, t[i].size, t[i].addr, 32'h0, t[i].mrd, 0,
                   sc, rc, rd, be, wdo, ao, weo, es);
      e = sb.pop_front();
      vectors++;
      if (rd !== e.rd || sc !== e.stall) begin
        miscompares++;
        $display("FAIL load%0d rd=%h stall=%0d want %h/%0d",
                 i, rd, sc, e.rd, e.stall);
      end
      vectors++;
      if (be !== t[i].be || ao !== {t[i].addr[31:2], 2'b00}) begin
        miscompares++;
        $display("FAIL load%0d_be be=%b addr=%h want %b",
                 i, be, ao, t[i].be);
      end
    end
  endtask

  task automatic test_stores;
    logic [2:0]  sz[3];
    logic [31:0] ad[3], wd[3], xw[3], xa[3];
    logic [3:0]  xb[3];
    int sc, rc; logic [31:0] rd, wdo, ao; logic [3:0] be;
    logic weo; bit es; exp_t e;
    sz[0] = 3'd0; ad[0] = 32'h201; wd[0] = 32'h1234_56AB;
    xb[0] = 4'b0010; xw[0] = 32'hABAB_ABAB; xa[0] = 32'h200;
    sz[1] = 3'd1; ad[1] = 32'h202; wd[1] = 32'h1234_56AB;
    xb[1] = 4'b1100; xw[1] = 32'h56AB_56AB; xa[1] = 32'h200;
    sz[2] = 3'd2; ad[2] = 32'h204; wd[2] = 32'hCAFE_F00D;
    xb[2] = 4'b1111; xw[2] = 32'hCAFE_F00D; xa[2] = 32'h204;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{32'h0, 1, 1'b0});
      drive_access(1'b1, sz[i], ad[i], wd[i], 32'h0, 0,
                   sc, rc, rd, be, wdo, ao, weo, es);
      e = sb.pop_front();
      vectors++;
      if (sc !== e.stall || weo !== 1'b1) begin
        miscompares++;
        $display("FAIL store%0d stall=%0d we=%b want %0d/1",
                 i, sc, weo, e.stall);
      end
      vectors++;
      if (be !== xb[i] || wdo !== xw[i] || ao !== xa[i]) begin
        miscompares++;
        $display("FAIL store%0d_bus be=%b wd=%h a=%h want %b/%h/%h",
                 i, be, wdo, ao, xb[i], xw[i], xa[i]);
      end
    end
  endtask

  task automatic test_wait;
    int sc, rc; logic [31:0] rd, wdo, ao; logic [3:0] be;
    logic weo; bit es; exp_t e;
    sb.push_back('{32'h0BAD_F00D, 4, 1'b1});
    drive_access(1'b0, 3'd2, 32'h40, 32'h0, 32'h0BAD_F00D, 3,
                 sc, rc, rd, be, wdo, ao, weo, es);
    e = sb.pop_front();
    vectors++;
    if (sc !== e.stall || rc !== 4) begin
      miscompares++;
      $display("FAIL wait_stall stall=%0d req=%0d want %0d/4",
               sc, rc, e.stall);
    end
    vectors++;
    if (rd !== e.rd || es !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_rd got=%h err=%b want %h/0", rd, es, e.rd);
    end
  endtask

  task automatic test_illegal;
    logic [2:0]  sz[3];
    logic [31:0] ad[3];
    logic        we[3];
    sz[0] = 3'd2; ad[0] = 32'h102; we[0] = 1'b0;
    sz[1] = 3'd4; ad[1] = 32'h100; we[1] = 1'b1;
    sz[2] = 3'd3; ad[2] = 32'h100; we[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      core_req_i = 1'b1; core_we_i = we[i];
      core_size_i = sz[i]; core_addr_i = ad[i];
      bus.ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.req !== 1'b0 || core_stall_o !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal%0d_req req=%b stall=%b want 0/0",
                 i, bus.req, core_stall_o);
      end
      @(posedge clk); #1;
      core_req_i = 1'b0;
      bus.ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (core_err_o !== 1'b1 || core_stall_o !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal%0d_err err=%b stall=%b want 1/0",
                 i, core_err_o, core_stall_o);
      end
      @(negedge clk);
      vectors++;
      if (core_err_o !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal%0d_pulse err=%b want 0", i, core_err_o);
      end
    end
  endtask

  task automatic test_timeout;
    int rc;
    bit seen_err;
    rc = 0; seen_err = 0;
    @(posedge clk); #1;
    core_req_i = 1'b1; core_we_i = 1'b0;
    core_size_i = 3'd2; core_addr_i = 32'h300;
    bus.ready = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (core_err_o && bus.req) seen_err = 1;
      if (!bus.req) break;
      rc++;
      @(posedge clk); #1;
    end
    vectors++;
    if (rc !== 16 || seen_err) begin
      miscompares++;
      $display("FAIL timeout_cycles got=%0d want=16", rc);
    end
    vectors++;
    if (core_err_o !== 1'b1 || core_stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_err err=%b stall=%b want 1/0",
               core_err_o, core_stall_o);
    end
    @(posedge clk); #1;
    core_req_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (core_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse err=%b want 0", core_err_o);
    end
  endtask

  task automatic test_reset_mid;
    int sc, rc; logic [31:0] rd, wdo, ao; logic [3:0] be;
    logic weo; bit es; exp_t e;
    @(posedge clk); #1;
    core_req_i = 1'b1; core_we_i = 1'b0;
    core_size_i = 3'd2; core_addr_i = 32'h500;
    bus.ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #3;
    rst_i = 1'b0;
    #1;
    vectors++;
    if (bus.req !== 1'b0 || core_stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async req=%b stall=%b want 0/0",
               bus.req, core_stall_o);
    end
    core_req_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    sb.push_back('{32'h5A5A_1234, 1, 1'b1});
    drive_access(1'b0, 3'd2, 32'h500, 32'h0, 32'h5A5A_1234, 0,
                 sc, rc, rd, be, wdo, ao, weo, es);
    e = sb.pop_front();
    vectors++;
    if (rd !== e.rd || sc !== e.stall || es !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_lw rd=%h stall=%0d err=%b want %h/%0d/0",
               rd, sc, es, e.rd, e.stall);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   rc;
    rc = 0;
    sb.push_back('{32'h1111_1111, 1, 1'b1});
    sb.push_back('{32'h2222_2222, 1, 1'b1});
    @(posedge clk); #1;
    core_req_i = 1'b1; core_we_i = 1'b0;
    core_size_i = 3'd2; core_addr_i = 32'h600;
    bus.rd = 32'h1111_1111; bus.ready = 1'b1;
    @(negedge clk);
    if (bus.req && bus.addr == 32'h600) rc++;
    @(posedge clk); #1;
    core_addr_i = 32'h604;
    bus.rd = 32'h2222_2222;
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    if (core_rd_o !== e.rd || core_stall_o !== 1'b0 ||
        bus.req !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_first rd=%h stall=%b req=%b want %h/0/0",
               core_rd_o, core_stall_o, bus.req, e.rd);
    end
    @(posedge clk); #1;
    @(negedge clk);
    if (bus.req && bus.addr == 32'h604 && core_stall_o) rc++;
    @(posedge clk); #1;
    core_req_i = 1'b0;
    bus.ready = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    if (core_rd_o !== e.rd || core_stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second rd=%h stall=%b want %h/0",
               core_rd_o, core_stall_o, e.rd);
    end
    vectors++;
    if (rc !== 2) begin
      miscompares++;
      $display("FAIL b2b_reqs got=%0d want=2", rc);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_stores();
    test_wait();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
